cpu_core_mc: RTL and testbench
==============================

Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit CPU top.
- Same field-sliced 16-bit instruction format, with generic data and PC widths.
- Adds immediates, load/store, branches/jump and HALT.
- Fetches instructions and accesses data through external req/valid memory handshakes, so memories may insert wait states.
- Internal FSM sequences FETCH/DECODE/EXEC/MEM/WB; the 8-entry register file and ALU are internal.

Parameters:
- DATA_W, 16, datapath and register width (>=8).
- PC_W, 16, instruction word-address width.
- DMEM_AW, 16, data word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch word address (= pc).
- imem_rdata  in  16  instruction word, valid when imem_valid.
- imem_valid  in  1  fetch completion.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DMEM_AW  data word address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data, valid when dmem_valid.
- dmem_valid  in  1  data access completion.
- pc  out  PC_W  current program counter.
- result  out  DATA_W  last value written to the register file.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped on HALT.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=0; all registers=0; result=0.
  - imem_req, dmem_req, dmem_we, retire and halted all 0.
  - State = FETCH, taking effect from the first edge after release.
  - Reset mid-instruction aborts it with no register or memory write.
- Instruction fields: op=[15:12].
  - R-type: rd=[5:3], rs1=[11:9], rs2=[8:6].
  - I-type: ra=[11:9], rb=[8:6], imm6=[5:0], sign-extended to DATA_W.
  - J-type: imm12=[11:0], sign-extended.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd = rs1 op rs2.
  - 5 SLT: rd = 1 if signed rs1 < rs2, else 0.
  - 6 SHL, 7 SHR (logical): shift amount = rs2[log2(DATA_W)-1:0].
  - 8 ADDI: ra = rb + imm.
  - 9 LW: ra = mem[rb + imm].
  - A SW: mem[rb + imm] = ra.
  - B BEQ / C BNE: if ra ==/!= rb, pc = pc + 1 + imm6.
  - D JMP: pc = pc + 1 + imm12.
  - E NOP.
  - F HALT.
- Arithmetic wraps modulo 2^DATA_W; pc wraps modulo 2^PC_W; dmem_addr = low DMEM_AW bits of rb + imm.
- r0 always reads 0; writes to r0 are discarded, but result still updates with the computed value.
- FSM:
  - FETCH: imem_req=1, imem_addr=pc held stable. On the edge where imem_valid=1, latch instr and go to DECODE; imem_req drops the next cycle.
  - DECODE (1 cycle): read operands into A/B registers.
  - EXEC (1 cycle): ALU result, effective address, branch decision. LW/SW go to MEM; HALT goes to HALT; all others go to WB.
  - MEM: dmem_req=1; addr, we and wdata held stable until dmem_valid=1. An LW latches dmem_rdata on that edge. Then go to WB.
  - WB (1 cycle): register write when applicable; result updated on writes; pc updated (pc+1 or target); retire=1; next state FETCH.
  - HALT: halted=1 and no requests; only reset exits. HALT does not retire.
- Latency with valid returned in the same cycle as req: ALU/branch/jump/NOP instructions take 4 cycles, LW/SW take 5. Each wait cycle on a valid adds 1.
- imem_valid and dmem_valid are ignored when their respective req is 0.
- Branch/jump operands are read in DECODE, so there are no hazards; the core is strictly non-overlapped.

Test Plan:
- Zero-wait memories; program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> after 12 cycles three retire pulses, result=2, r3=2, pc=3.
- ADDI r1,r0,7; SW r1,[r0+4]; LW r2,[r0+4] -> dmem write at addr 4 with data 7; the load's req has dmem_we=0; r2=7; the SW/LW instructions each take 5 cycles.
- r1=r2=1; BEQ r1,r2,+2 at pc=10 -> next fetch addr 13. Same with BNE -> next fetch addr 11. JMP -1 -> pc unchanged, self-loop.
- imem_valid delayed 3 cycles, dmem_valid delayed 2 -> req and addr held stable throughout, instruction completes 3/2 cycles later, no duplicate writes.
- ADDI r0,r0,9 -> result=9 and r0 still reads 0. HALT -> halted=1, no further imem_req for 20 cycles. Assert reset mid-MEM -> outputs return to reset values immediately, fetch restarts at pc=0.

Source files
------------

// File: rtl/cpu_core_mc_if.sv
// Memory-side bus of the multi-cycle core: instruction fetch and data access
// channels, each a req/valid handshake so memories may stretch an access.
interface cpu_core_mc_if #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 16,
    parameter int DMEM_AW = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [15:0]        imem_rdata;
    logic               imem_valid;

    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata;
    logic               dmem_valid;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_valid,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_valid
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_valid,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_valid
    );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle 16-bit-instruction CPU core: FETCH/DECODE/EXEC/MEM/WB sequencing
// with an internal 8-entry register file and handshaked instruction/data memories.
module cpu_core_mc #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 16,
    parameter int DMEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    cpu_core_mc_if.master     mem,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] result,
    output logic              retire,
    output logic              halted
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int AX_W = (DMEM_AW > DATA_W) ? DMEM_AW : DATA_W;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t             state, state_nxt;
    logic [15:0]        instr;
    logic [DATA_W-1:0]  a_q, b_q, alu_q, load_q;
    logic [DMEM_AW-1:0] addr_q;
    logic [PC_W-1:0]    pc_nxt_q;
    logic [DATA_W-1:0]  regs [0:7];

    logic [3:0]         op;
    logic [2:0]         ra_idx, rb_idx, rd_idx, dst_idx;
    logic [DATA_W-1:0]  imm_d, alu_val, wb_val;
    logic [PC_W-1:0]    imm6_p, imm12_p, pc_plus1, pc_target;
    logic [AX_W-1:0]    addr_ext;
    logic               taken, writes_reg;
    logic               imem_req_c, dmem_req_c, dmem_we_c;

    assign op       = instr[15:12];
    assign ra_idx   = instr[11:9];
    assign rb_idx   = instr[8:6];
    assign rd_idx   = instr[5:3];
    assign imm_d    = DATA_W'($signed(instr[5:0]));
    assign imm6_p   = PC_W'($signed(instr[5:0]));
    assign imm12_p  = PC_W'($signed(instr[11:0]));
    assign pc_plus1 = pc + PC_W'(1);

    // Register-type ops write rd; ADDI and LW write ra (same field as rs1).
    assign writes_reg = (op <= OP_LW);
    assign dst_idx    = (op <= OP_SHR) ? rd_idx : ra_idx;
    assign wb_val     = (op == OP_LW) ? load_q : alu_q;

    always_comb begin
        alu_val = '0;
        case (op)
            OP_ADD:  alu_val = a_q + b_q;
            OP_SUB:  alu_val = a_q - b_q;
            OP_AND:  alu_val = a_q & b_q;
            OP_OR:   alu_val = a_q | b_q;
            OP_XOR:  alu_val = a_q ^ b_q;
            OP_SLT:  alu_val = DATA_W'($signed(a_q) < $signed(b_q));
            OP_SHL:  alu_val = a_q << b_q[SH_W-1:0];
            OP_SHR:  alu_val = a_q >> b_q[SH_W-1:0];
            default: alu_val = b_q + imm_d;
        endcase
    end

    assign addr_ext  = AX_W'(alu_val);
    assign taken     = ((op == OP_BEQ) && (a_q == b_q)) || ((op == OP_BNE) && (a_q != b_q));
    assign pc_target = pc_plus1 + ((op == OP_JMP) ? imm12_p : imm6_p);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            result   <= '0;
            instr    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            load_q   <= '0;
            addr_q   <= '0;
            pc_nxt_q <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH: begin
                    if (mem.imem_valid) instr <= mem.imem_rdata;
                end
                S_DECODE: begin
                    a_q <= regs[ra_idx];
                    b_q <= regs[rb_idx];
                end
                S_EXEC: begin
                    alu_q    <= alu_val;
                    addr_q   <= addr_ext[DMEM_AW-1:0];
                    pc_nxt_q <= (taken || (op == OP_JMP)) ? pc_target : pc_plus1;
                end
                S_MEM: begin
                    if (mem.dmem_valid && (op == OP_LW)) load_q <= mem.dmem_rdata;
                end
                S_WB: begin
                    pc <= pc_nxt_q;
                    // r0 stays zero but result still shows the discarded value.
                    if (writes_reg) begin
                        result <= wb_val;
                        if (dst_idx != 3'd0) regs[dst_idx] <= wb_val;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_valid) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if ((op == OP_LW) || (op == OP_SW)) state_nxt = S_MEM;
                else if (op == OP_HALT)              state_nxt = S_HALT;
                else                                 state_nxt = S_WB;
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op == OP_SW);
                if (mem.dmem_valid) state_nxt = S_WB;
            end
            S_WB: begin
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign mem.imem_req   = imem_req_c;
    assign mem.imem_addr  = pc;
    assign mem.dmem_req   = dmem_req_c;
    assign mem.dmem_we    = dmem_we_c;
    assign mem.dmem_addr  = addr_q;
    assign mem.dmem_wdata = a_q;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: behavioural wait-state memories, a retire
// scoreboard of expected result/pc, and access/fetch logs checked per program.
module tb_cpu_core_mc;
    localparam int DATA_W  = 16;
    localparam int PC_W    = 16;
    localparam int DMEM_AW = 16;

    typedef struct {
        logic [15:0] res;
        logic [15:0] pc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] result;
    logic              retire;
    logic              halted;

    exp_t        sb_q[$];
    acc_t        acc_q[$];
    logic [15:0] fetch_q[$];
    int          retire_cyc_q[$];
    logic [15:0] imem [0:255];
    logic [15:0] dmem [0:255];

    int   errors = 0;
    int   checks = 0;
    int   cycle_cnt = 0;
    int   release_cyc = 0;
    int   imem_wait = 0;
    int   dmem_wait = 0;
    int   stab_err = 0;
    logic mon_busy = 1'b0;

    cpu_core_mc_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) bus ();

    cpu_core_mc #(.DATA_W(DATA_W), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem    (bus.master),
        .pc     (pc),
        .result (result),
        .retire (retire),
        .halted (halted)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle_cnt++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {op[3:0], rs1[2:0], rs2[2:0], rd[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int ra, input int rb, input int imm);
        return {op[3:0], ra[2:0], rb[2:0], imm[5:0]};
    endfunction

    function automatic logic [15:0] enc_j(input int op, input int imm);
        return {op[3:0], imm[11:0]};
    endfunction

    function automatic int rel_retire(input int i);
        if (i < retire_cyc_q.size()) return retire_cyc_q[i] - release_cyc;
        return -1;
    endfunction

    function automatic logic [32:0] acc_word(input int i);
        if (i < acc_q.size()) return {acc_q[i].we, acc_q[i].addr, acc_q[i].data};
        return '1;
    endfunction

    function automatic logic [15:0] fetch_at(input int i);
        if (i < fetch_q.size()) return fetch_q[i];
        return 16'hDEAD;
    endfunction

    // Memory model: valid is given on the (wait+1)-th cycle of a request and
    // the address/control of a stretched request must not move meanwhile.
    initial begin
        int          icnt;
        int          dcnt;
        logic [15:0] ihold;
        logic [32:0] dhold;
        icnt = 0;
        dcnt = 0;
        ihold = '0;
        dhold = '0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_valid = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset || !bus.imem_req) begin
                bus.imem_valid = 1'b0;
                icnt = 0;
            end else begin
                if (icnt == 0) ihold = bus.imem_addr;
                else if (bus.imem_addr !== ihold) stab_err++;
                if (icnt >= imem_wait) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = imem[bus.imem_addr[7:0]];
                    fetch_q.push_back(bus.imem_addr);
                    icnt = 0;
                end else begin
                    bus.imem_valid = 1'b0;
                    icnt++;
                end
            end
            if (!reset || !bus.dmem_req) begin
                bus.dmem_valid = 1'b0;
                dcnt = 0;
            end else begin
                if (dcnt == 0) dhold = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
                else if ({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== dhold) stab_err++;
                if (dcnt >= dmem_wait) begin
                    bus.dmem_valid = 1'b1;
                    if (bus.dmem_we) begin
                        dmem[bus.dmem_addr[7:0]] = bus.dmem_wdata;
                        acc_q.push_back('{1'b1, bus.dmem_addr, bus.dmem_wdata});
                    end else begin
                        bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
                        acc_q.push_back('{1'b0, bus.dmem_addr, dmem[bus.dmem_addr[7:0]]});
                    end
                    dcnt = 0;
                end else begin
                    bus.dmem_valid = 1'b0;
                    dcnt++;
                end
            end
        end
    end

    // Retire monitor: each pulse pops one expectation; result/pc are compared
    // just after the write-back edge, when they have taken the new values.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (retire === 1'b1) begin
            mon_busy = 1'b1;
            retire_cyc_q.push_back(cycle_cnt);
            check_output("retire_expected", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) e = sb_q.pop_front();
            else e = '{16'hxxxx, 16'hxxxx};
            @(posedge clk);
            #1;
            check_output("retire_result", result, e.res);
            check_output("retire_pc", pc, e.pc);
            check_output("retire_pulse", retire, 0);
            mon_busy = 1'b0;
        end
    end

    task automatic start_test(input int iw, input int dw);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        imem_wait = iw;
        dmem_wait = dw;
        sb_q.delete();
        acc_q.delete();
        fetch_q.delete();
        retire_cyc_q.delete();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 16'h0000;
        end
    endtask

    task automatic apply_stimulus(input int addr, input logic [15:0] word,
                                  input logic [15:0] exp_res, input logic [15:0] exp_pc);
        imem[addr] = word;
        sb_q.push_back('{exp_res, exp_pc});
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        release_cyc = cycle_cnt;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, (sb_q.size() == 0), 1);
    endtask

    task automatic wait_halt(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, halted, 1);
    endtask

    initial begin
        int req_seen;
        int n;

        repeat (2) @(negedge clk);
        check_output("rst_pc", pc, 0);
        check_output("rst_result", result, 0);
        check_output("rst_imem_req", bus.imem_req, 0);
        check_output("rst_dmem_req", bus.dmem_req, 0);
        check_output("rst_dmem_we", bus.dmem_we, 0);
        check_output("rst_retire", retire, 0);
        check_output("rst_halted", halted, 0);

        $display("[TB] program 1: ADDI/ADDI/ADD, zero-wait");
        start_test(0, 0);
        apply_stimulus(0, enc_i(8, 1, 0, 5),   16'h0005, 16'd1);
        apply_stimulus(1, enc_i(8, 2, 0, -3),  16'hFFFD, 16'd2);
        apply_stimulus(2, enc_r(0, 3, 1, 2),   16'h0002, 16'd3);
        apply_stimulus(3, enc_i(10, 3, 0, 20), 16'h0002, 16'd4);
        release_reset();
        wait_done("p1_done", 100);
        wait_halt("p1_halt", 20);
        check_output("p1_ret0_cyc", rel_retire(0), 4);
        check_output("p1_ret1_cyc", rel_retire(1), 8);
        check_output("p1_ret2_cyc", rel_retire(2), 12);
        check_output("p1_nacc", acc_q.size(), 1);
        check_output("p1_store_r3", acc_word(0), {1'b1, 16'd20, 16'd2});
        req_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) req_seen++;
        end
        check_output("halt_no_req", req_seen, 0);
        check_output("halt_stays", halted, 1);
        check_output("halt_pc", pc, 4);

        $display("[TB] program 2: store then load");
        start_test(0, 0);
        apply_stimulus(0, enc_i(8, 1, 0, 7),  16'd7, 16'd1);
        apply_stimulus(1, enc_i(10, 1, 0, 4), 16'd7, 16'd2);
        apply_stimulus(2, enc_i(9, 2, 0, 4),  16'd7, 16'd3);
        apply_stimulus(3, enc_i(10, 2, 0, 5), 16'd7, 16'd4);
        release_reset();
        wait_done("p2_done", 100);
        wait_halt("p2_halt", 20);
        check_output("p2_sw_cyc", rel_retire(1), 9);
        check_output("p2_lw_cyc", rel_retire(2), 14);
        check_output("p2_nacc", acc_q.size(), 3);
        check_output("p2_sw_acc", acc_word(0), {1'b1, 16'd4, 16'd7});
        check_output("p2_lw_acc", acc_word(1), {1'b0, 16'd4, 16'd7});
        check_output("p2_r2_store", acc_word(2), {1'b1, 16'd5, 16'd7});

        $display("[TB] program 3: branches, NOP and jump self-loop");
        start_test(0, 0);
        apply_stimulus(0,  enc_i(8, 1, 0, 1),  16'd1, 16'd1);
        apply_stimulus(1,  enc_i(8, 2, 0, 1),  16'd1, 16'd2);
        apply_stimulus(2,  enc_j(13, 7),       16'd1, 16'd10);
        apply_stimulus(10, enc_i(11, 1, 2, 2), 16'd1, 16'd13);
        apply_stimulus(13, enc_i(12, 1, 2, 2), 16'd1, 16'd14);
        apply_stimulus(14, enc_i(12, 1, 0, 1), 16'd1, 16'd16);
        apply_stimulus(16, 16'hE000,           16'd1, 16'd17);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(17, enc_j(13, -1), 16'd1, 16'd17);
        end
        release_reset();
        wait_done("p3_done", 200);
        check_output("p3_fetch_jmp", fetch_at(3), 10);
        check_output("p3_fetch_beq", fetch_at(4), 13);
        check_output("p3_fetch_bne_nt", fetch_at(5), 14);
        check_output("p3_fetch_bne_t", fetch_at(6), 16);
        check_output("p3_fetch_loop", fetch_at(8), 17);

        $display("[TB] program 4: ALU ops and r0 writes");
        start_test(0, 0);
        apply_stimulus(0,  enc_i(8, 1, 0, -6), 16'hFFFA, 16'd1);
        apply_stimulus(1,  enc_i(8, 2, 0, 3),  16'h0003, 16'd2);
        apply_stimulus(2,  enc_r(1, 3, 1, 2),  16'hFFF7, 16'd3);
        apply_stimulus(3,  enc_r(2, 4, 1, 2),  16'h0002, 16'd4);
        apply_stimulus(4,  enc_r(3, 4, 1, 2),  16'hFFFB, 16'd5);
        apply_stimulus(5,  enc_r(4, 4, 1, 2),  16'hFFF9, 16'd6);
        apply_stimulus(6,  enc_r(5, 4, 1, 2),  16'h0001, 16'd7);
        apply_stimulus(7,  enc_r(5, 4, 2, 1),  16'h0000, 16'd8);
        apply_stimulus(8,  enc_r(6, 4, 2, 2),  16'h0018, 16'd9);
        apply_stimulus(9,  enc_r(7, 4, 1, 2),  16'h1FFF, 16'd10);
        apply_stimulus(10, enc_i(8, 0, 0, 9),  16'h0009, 16'd11);
        apply_stimulus(11, enc_i(8, 5, 0, 1),  16'h0001, 16'd12);
        release_reset();
        wait_done("p4_done", 200);
        wait_halt("p4_halt", 20);
        check_output("p4_halt_pc", pc, 12);

        $display("[TB] program 5: wait states imem=3 dmem=2");
        start_test(3, 2);
        apply_stimulus(0, enc_i(8, 1, 0, 6),  16'd6, 16'd1);
        apply_stimulus(1, enc_i(10, 1, 0, 8), 16'd6, 16'd2);
        apply_stimulus(2, enc_i(9, 3, 0, 8),  16'd6, 16'd3);
        release_reset();
        wait_done("p5_done", 200);
        wait_halt("p5_halt", 40);
        check_output("p5_addi_cyc", rel_retire(0), 7);
        check_output("p5_sw_cyc", rel_retire(1), 17);
        check_output("p5_lw_cyc", rel_retire(2), 27);
        check_output("p5_nacc", acc_q.size(), 2);
        check_output("p5_sw_acc", acc_word(0), {1'b1, 16'd8, 16'd6});
        check_output("p5_lw_acc", acc_word(1), {1'b0, 16'd8, 16'd6});
        check_output("p5_stable", stab_err, 0);

        $display("[TB] program 6: reset asserted during MEM");
        start_test(0, 50);
        apply_stimulus(0, enc_i(8, 1, 0, 5), 16'd5, 16'd1);
        imem[1] = enc_i(10, 1, 0, 30);
        release_reset();
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("p6_in_mem", bus.dmem_req, 1);
        repeat (3) @(negedge clk);
        imem[0] = 16'hF000;
        #2;
        reset = 1'b0;
        #1;
        check_output("p6_rst_dmem_req", bus.dmem_req, 0);
        check_output("p6_rst_dmem_we", bus.dmem_we, 0);
        check_output("p6_rst_imem_req", bus.imem_req, 0);
        check_output("p6_rst_pc", pc, 0);
        check_output("p6_rst_result", result, 0);
        check_output("p6_rst_retire", retire, 0);
        release_reset();
        @(posedge clk);
        #1;
        check_output("p6_refetch_req", bus.imem_req, 1);
        check_output("p6_refetch_addr", bus.imem_addr, 0);
        wait_halt("p6_halt", 20);
        check_output("p6_no_write", acc_q.size(), 0);
        check_output("p6_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
